// File: rtl/pov_column_streamer.sv
// pov_column_streamer: CPU-mapped POV framebuffer that streams one column per theta change.
// Optional POV_COLUMN_STREAMER_DOUBLE_BUFFER_EN adds a second bank with frame-synchronous swap.
module pov_column_streamer #(
  parameter int          N_COLS    = 256,
  parameter int          N_LEDS    = 8,
  parameter int          THETA_W   = 6,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
  localparam int         COL_W     = $clog2(N_COLS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_data_in,
  input  logic               cpu_wren,
  input  logic               cpu_rden,
  output logic [31:0]        cpu_data_out,
  input  logic [THETA_W-1:0] theta,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [23:0]        pix_data,
  output logic               pix_last,
  output logic [COL_W-1:0]   pix_col
);

  localparam int LED_W = $clog2(N_LEDS);
  localparam int SHIFT = COL_W - THETA_W;
`ifdef POV_COLUMN_STREAMER_DOUBLE_BUFFER_EN
  localparam int BANK_W = 1;
`else
  localparam int BANK_W = 0;
`endif
  localparam int AW    = BANK_W + COL_W + LED_W;
  localparam int DEPTH = 1 << AW;

  localparam logic [LED_W-1:0] LED_MAX = LED_W'(N_LEDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_STREAM
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [THETA_W-1:0] r_theta;
  logic [THETA_W-1:0] r_theta_prev;
  logic [COL_W-1:0]   w_cur_col;
  logic               w_col_event;

  logic [COL_W-1:0]   r_col;
  logic [LED_W-1:0]   r_led;
  logic               r_pend_valid;
  logic [COL_W-1:0]   r_pend_col;

  logic               w_start;
  logic [COL_W-1:0]   w_src_col;
  logic               w_led_inc;
  logic               w_last_led;
  logic               w_want_scan;

  logic [COL_W-1:0]   r_wcol;
  logic [LED_W-1:0]   r_wled;
  logic               r_enable;
  logic [15:0]        r_frame_cnt;
  logic [31:0]        r_cpu_data_out;
  logic [31:0]        w_rd_val;

  logic [23:0]        r_mem [DEPTH];
  logic [23:0]        r_rd_data;
  logic [AW-1:0]      w_rd_addr;
  logic [AW-1:0]      w_wr_addr;
  logic               w_pix_wr;

  logic               w_bank;
  logic               w_swap_pend;
  logic               w_busy;

  logic               w_sel_col;
  logic               w_sel_led;
  logic               w_sel_pix;
  logic               w_sel_stat;
  logic               w_sel_ctrl;
  logic               w_sel_frame;

  logic               w_unused;

  assign w_unused = ^{cpu_data_in[31:24], cpu_data_in[1]};

  assign w_sel_col   = cpu_addr == BASE_ADDR;
  assign w_sel_led   = cpu_addr == BASE_ADDR + 32'h04;
  assign w_sel_pix   = cpu_addr == BASE_ADDR + 32'h08;
  assign w_sel_stat  = cpu_addr == BASE_ADDR + 32'h0C;
  assign w_sel_ctrl  = cpu_addr == BASE_ADDR + 32'h10;
  assign w_sel_frame = cpu_addr == BASE_ADDR + 32'h14;

  assign w_pix_wr = cpu_wren && w_sel_pix;

  // Theta is widened to the column space; low bits are zero.
  assign w_cur_col   = COL_W'(r_theta) << SHIFT;
  assign w_col_event = r_theta != r_theta_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_theta      <= '0;
      r_theta_prev <= '0;
    end else begin
      r_theta      <= theta;
      r_theta_prev <= r_theta;
    end
  end

  assign w_last_led  = r_led == LED_MAX;
  assign w_want_scan = r_enable && (w_col_event || r_pend_valid);
  // A fresh event is newer than anything parked in the pending slot.
  assign w_src_col   = w_col_event ? w_cur_col : r_pend_col;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_led_inc    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_want_scan) begin
          w_start      = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next_state = S_STREAM;
      end
      S_STREAM: begin
        if (pix_ready) begin
          if (!w_last_led) begin
            w_led_inc    = 1'b1;
            w_next_state = S_FETCH;
          end else if (w_want_scan) begin
            w_start      = 1'b1;
            w_next_state = S_FETCH;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_col   <= '0;
    end else if (!r_enable || w_start) begin
      r_pend_valid <= 1'b0;
    end else if (w_col_event && r_state != S_IDLE) begin
      r_pend_valid <= 1'b1;
      r_pend_col   <= w_cur_col;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_led <= '0;
    end else if (w_start) begin
      r_col <= w_src_col;
      r_led <= '0;
    end else if (w_led_inc) begin
      r_led <= r_led + LED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                         r_frame_cnt <= '0;
    else if (w_start && w_src_col == '0) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

`ifdef POV_COLUMN_STREAMER_DOUBLE_BUFFER_EN
  logic r_bank;
  logic r_swap_pend;

  // Swap lands on the scan-start edge so the following FETCH reads the new bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank      <= 1'b0;
      r_swap_pend <= 1'b0;
    end else begin
      if (w_start && w_src_col == '0 && r_swap_pend) begin
        r_bank      <= ~r_bank;
        r_swap_pend <= 1'b0;
      end
      if (cpu_wren && w_sel_ctrl && cpu_data_in[1]) r_swap_pend <= 1'b1;
    end
  end

  assign w_bank      = r_bank;
  assign w_swap_pend = r_swap_pend;
  assign w_rd_addr   = {r_bank, r_col, r_led};
  assign w_wr_addr   = {~r_bank, r_wcol, r_wled};
`else
  assign w_bank      = 1'b0;
  assign w_swap_pend = 1'b0;
  assign w_rd_addr   = {r_col, r_led};
  assign w_wr_addr   = {r_wcol, r_wled};
`endif

  always_ff @(posedge clk) begin
    if (w_pix_wr) r_mem[w_wr_addr] <= cpu_data_in[23:0];
  end

  always_ff @(posedge clk) begin
    if (reset)                  r_rd_data <= '0;
    else if (r_state == S_FETCH) r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wcol   <= '0;
      r_wled   <= '0;
      r_enable <= 1'b0;
    end else if (cpu_wren) begin
      unique case (1'b1)
        w_sel_col:  r_wcol   <= cpu_data_in[COL_W-1:0];
        w_sel_led:  r_wled   <= cpu_data_in[LED_W-1:0];
        w_sel_ctrl: r_enable <= cpu_data_in[0];
        w_sel_pix: begin
          if (r_wled == LED_MAX) begin
            r_wled <= '0;
            r_wcol <= r_wcol + COL_W'(1);
          end else begin
            r_wled <= r_wled + LED_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_busy = r_state != S_IDLE;

  always_comb begin
    w_rd_val = '0;
    unique case (1'b1)
      w_sel_stat:  w_rd_val = {21'd0, w_bank, w_swap_pend, w_busy, 8'(w_cur_col)};
      w_sel_ctrl:  w_rd_val = {31'd0, r_enable};
      w_sel_frame: w_rd_val = {16'd0, r_frame_cnt};
      default:     w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         r_cpu_data_out <= '0;
    else if (cpu_rden) r_cpu_data_out <= w_rd_val;
  end

  assign cpu_data_out = r_cpu_data_out;
  assign pix_valid    = r_state == S_STREAM;
  assign pix_last     = pix_valid && w_last_led;
  assign pix_data     = r_rd_data;
  assign pix_col      = r_col;

endmodule

// File: tb/tb_pov_column_streamer.sv
// tb_pov_column_streamer: scoreboard bench for pov_column_streamer.
// Expected beats are queued when theta is driven and popped on each handshake.
`timescale 1ns/1ps
module tb_pov_column_streamer;

  localparam int N_COLS  = 256;
  localparam int N_LEDS  = 8;
  localparam int THETA_W = 6;
  localparam logic [31:0] BASE = 32'hFFFF0000;
  localparam logic [31:0] A_COL   = BASE + 32'h00;
  localparam logic [31:0] A_LED   = BASE + 32'h04;
  localparam logic [31:0] A_PIX   = BASE + 32'h08;
  localparam logic [31:0] A_STAT  = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL  = BASE + 32'h10;
  localparam logic [31:0] A_FRAME = BASE + 32'h14;
  localparam logic [31:0] A_NONE  = BASE + 32'h18;
`ifdef POV_COLUMN_STREAMER_DOUBLE_BUFFER_EN
  localparam logic DB = 1'b1;
`else
  localparam logic DB = 1'b0;
`endif

  logic               clk;
  logic               reset;
  logic [31:0]        cpu_addr;
  logic [31:0]        cpu_data_in;
  logic               cpu_wren;
  logic               cpu_rden;
  logic [31:0]        cpu_data_out;
  logic [THETA_W-1:0] theta;
  logic               pix_valid;
  logic               pix_ready;
  logic [23:0]        pix_data;
  logic               pix_last;
  logic [7:0]         pix_col;

  pov_column_streamer #(
    .N_COLS   (N_COLS),
    .N_LEDS   (N_LEDS),
    .THETA_W  (THETA_W),
    .BASE_ADDR(BASE)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_data_in (cpu_data_in),
    .cpu_wren    (cpu_wren),
    .cpu_rden    (cpu_rden),
    .cpu_data_out(cpu_data_out),
    .theta       (theta),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_data    (pix_data),
    .pix_last    (pix_last),
    .pix_col     (pix_col)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_hs = 0;
  logic first = 1'b1;
  logic spacing_en = 1'b0;
  logic [32:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && pix_valid && pix_ready) begin
      if (q.size() == 0) begin
        chk("sb_empty", 64'(q.size()), 64'd1);
      end else begin
        chk("beat", {pix_col, pix_last, pix_data}, q.pop_front());
      end
      if (spacing_en && !first) chk("gap", 64'(cyc - last_hs), 64'd2);
      first   = pix_last;
      last_hs = cyc;
      hs_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
    cpu_addr    = a;
    cpu_data_in = d;
    cpu_wren    = 1'b1;
    tick(1);
    cpu_wren    = 1'b0;
  endtask

  task automatic cpu_rd(input logic [31:0] a, output logic [31:0] d);
    cpu_addr = a;
    cpu_rden = 1'b1;
    tick(1);
    cpu_rden = 1'b0;
    d        = cpu_data_out;
  endtask

  task automatic push_beat(input logic [7:0] c, input logic [23:0] d,
                           input logic l);
    q.push_back({c, l, d});
  endtask

  task automatic push_col(input logic [7:0] c, input logic [23:0] base);
    for (int i = 0; i < N_LEDS; i++)
      push_beat(c, base + 24'(i), i == N_LEDS - 1);
  endtask

  task automatic push_col8();
    push_beat(8'd8, 24'h00FF00, 1'b0);
    for (int i = 1; i < N_LEDS; i++)
      push_beat(8'd8, 24'h80 + 24'(i), i == N_LEDS - 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q.size() != 0 || pix_valid) && n < 300) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(q.size()), 64'd0);
    q.delete();
    tick(2);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!pix_valid && n < 30) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(pix_valid), 64'd1);
  endtask

  logic [31:0] rd;
  logic [32:0] cap;
  int n;
  int base;

  initial begin
    reset       = 1'b1;
    cpu_addr    = '0;
    cpu_data_in = '0;
    cpu_wren    = 1'b0;
    cpu_rden    = 1'b0;
    theta       = '0;
    pix_ready   = 1'b0;
    tick(3);
    chk("rst_out", {cpu_data_out, pix_valid, pix_last, pix_col, pix_data}, 64'd0);
    reset = 1'b0;
    tick(1);
    cpu_rd(A_STAT, rd);  chk("rst_status", rd, 0);
    cpu_rd(A_CTRL, rd);  chk("rst_ctrl", rd, 0);
    cpu_rd(A_FRAME, rd); chk("rst_frame", rd, 0);

    cpu_wr(A_COL, 0);
    cpu_wr(A_LED, 0);
    for (int i = 0; i < N_LEDS; i++) cpu_wr(A_PIX, 32'h20 + i);
    cpu_wr(A_COL, 4);
    cpu_wr(A_LED, 0);
    for (int i = 0; i < N_LEDS; i++) cpu_wr(A_PIX, 32'h10 + i);
    cpu_wr(A_COL, 7);
    cpu_wr(A_LED, 7);
    cpu_wr(A_PIX, 32'hFF0000);
    cpu_wr(A_PIX, 32'h00FF00);
    for (int i = 1; i < N_LEDS; i++) cpu_wr(A_PIX, 32'h80 + i);

    // Disabled: theta change must not start a scan.
    theta = 6'd1;
    tick(5);
    chk("no_scan_dis", 64'(pix_valid), 64'd0);
    cpu_wr(A_CTRL, 32'h3);
    cpu_rd(A_CTRL, rd);  chk("ctrl_rd", rd, 1);
    cpu_rd(A_NONE, rd);  chk("unmapped", rd, 0);
    pix_ready = 1'b1;
    push_col(8'd0, 24'h20);
    theta = 6'd0;
    drain("swap_drain");
    cpu_rd(A_STAT, rd);  chk("swap_status", rd, 32'(DB) << 10);
    cpu_rd(A_FRAME, rd); chk("swap_frame", rd, 1);

    // Latency and beat spacing with pix_ready held high.
    spacing_en = 1'b1;
    push_col(8'd4, 24'h10);
    theta = 6'd1;
    n = 0;
    while (!pix_valid && n < 20) begin
      tick(1);
      n++;
    end
    chk("latency", 64'(n), 64'd3);
    drain("lat_drain");
    spacing_en = 1'b0;

    // Mid-column stall.
    push_col8();
    theta = 6'd2;
    base = hs_cnt;
    n = 0;
    while (hs_cnt < base + 3 && n < 100) begin
      tick(1);
      n++;
    end
    pix_ready = 1'b0;
    tick(1);
    chk("stall_valid", 64'(pix_valid), 64'd1);
    cap = {pix_last, pix_col, pix_data};
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall_hold", {pix_valid, pix_last, pix_col, pix_data}, {1'b1, cap});
    end
    pix_ready = 1'b1;
    drain("stall_drain");

    // Two theta changes during one scan: only the newest is kept.
    push_col(8'd4, 24'h10);
    push_col8();
    theta = 6'd1;
    wait_valid("two_start");
    tick(2);
    theta = 6'd0;
    tick(3);
    theta = 6'd2;
    drain("two_drain");
    cpu_rd(A_FRAME, rd); chk("two_frame", rd, 1);

    // Back-bank write then swap at the next column-0 scan.
    cpu_wr(A_COL, 0);
    cpu_wr(A_LED, 0);
    for (int i = 0; i < N_LEDS; i++) cpu_wr(A_PIX, 32'h30 + i);
    cpu_wr(A_CTRL, 32'h3);
    push_col(8'd4, 24'h10);
    theta = 6'd1;
    drain("bb_col4");
    push_col(8'd0, 24'h30);
    theta = 6'd0;
    drain("bb_col0");
    cpu_rd(A_STAT, rd);  chk("bb_status", rd, 0);
    cpu_rd(A_FRAME, rd); chk("bb_frame", rd, 2);

    // Reset while a beat is stalled in STREAM.
    pix_ready = 1'b0;
    theta = 6'd1;
    wait_valid("rst_mid_start");
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rst_mid", {cpu_data_out, pix_valid, pix_last, pix_col, pix_data}, 64'd0);
    reset = 1'b0;
    pix_ready = 1'b1;
    cpu_rd(A_FRAME, rd); chk("rst_mid_frame", rd, 0);
    cpu_rd(A_CTRL, rd);  chk("rst_mid_ctrl", rd, 0);
    cpu_wr(A_CTRL, 32'h1);
    push_col(8'd0, 24'h30);
    theta = 6'd0;
    drain("post_rst_drain");
    cpu_rd(A_FRAME, rd); chk("post_rst_frame", rd, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pov_column_streamer.md
# pov_column_streamer

Parametrised successor to the single-colour POV peripheral. It is a CPU memory-mapped framebuffer holding N_LEDS pixels per angular column over N_COLS columns, with optional double buffering and frame-synchronous swap. On every angular column change it streams that column's pixels to the LED driver over a valid/ready handshake. It sits between the CPU data bus, the theta_from_breakbeam position source and the LED serialiser.

## Interface
Parameters:
- N_COLS, 256: angular columns. Power of 2, and ≥ 2^THETA_W.
- N_LEDS, 8: pixels per column. Power of 2, range 2–64.
- THETA_W, 6: width of the theta input.
- BASE_ADDR, 32'hFFFF0000: register block base address.

Ports:
- clk  in  1  single clock; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high.
- cpu_addr  in  32  byte address.
- cpu_data_in  in  32  write data.
- cpu_wren  in  1  write strobe, one cycle per access.
- cpu_rden  in  1  read strobe, one cycle per access.
- cpu_data_out  out  32  registered read data.
- theta  in  THETA_W  angular position.
- pix_valid  out  1  pixel beat valid.
- pix_ready  in  1  LED driver accepts the beat.
- pix_data  out  24  RGB value of the beat.
- pix_last  out  1  marks the final LED of the column.
- pix_col  out  log2(N_COLS)  column index of the beat.

## Operation
- Register offsets from BASE_ADDR:
  - 0x00 COL_ADDR (W): column write pointer.
  - 0x04 LED_ADDR (W): LED write pointer.
  - 0x08 PIXEL_DATA (W): writes bits [23:0] to the write buffer at (col, led), then auto-increments. led wraps at N_LEDS-1 to 0 and col increments, wrapping modulo N_COLS.
  - 0x0C STATUS (R): [7:0] current column (low 8 bits), [8] busy (FSM not IDLE), [9] swap_pending, [10] display bank.
  - 0x10 CTRL (R/W): bit0 enable; bit1 write-1 sets swap_pending and reads as 0.
  - 0x14 FRAME_CNT (R): 16-bit count of column-0 scan starts, wrapping.
- Unmapped reads return 0. Unmapped writes are ignored.
- Column mapping: cur_col = theta << (log2(N_COLS) − THETA_W).
- Change detect: theta is registered once. A change against the previous registered value raises col_event.
- Storage is a dual-port RAM with 1-cycle registered read. Address = {bank, col, led}.
- FSM:
  - IDLE: on col_event with enable=1, latch the column, set led=0, go to FETCH.
  - FETCH: present the read address, go to STREAM.
  - STREAM: pix_valid=1. On pix_valid&pix_ready: if led==N_LEDS−1, go to IDLE; otherwise led++ and go to FETCH.
- A col_event arriving while not in IDLE is held in a 1-deep pending slot; newer events overwrite the slot. On leaving STREAM, a pending column goes straight to FETCH instead of IDLE.
- Swap: at the start of a scan whose latched column is 0 and swap_pending=1, the display bank toggles, swap_pending clears and FRAME_CNT increments. This all happens in the same cycle, before the FETCH address is issued. The CPU always writes the non-display bank.
- enable=0: a scan in progress completes; no new scans start; pending events are dropped.
- Reset mid-stream: the beat is abandoned with no pix_last. RAM contents are preserved and are not cleared by reset.

## Timing
- Reset values: cpu_data_out=0, pix_valid=0, pix_data=0, pix_last=0, pix_col=0. Pointers, CTRL, FRAME_CNT and bank are 0. FSM is IDLE. Pending slot is empty.
- theta change to first pix_valid: 3 cycles (theta register, IDLE→FETCH, FETCH→STREAM).
- Each beat costs at least 2 cycles, so a full column with pix_ready held high takes 2·N_LEDS cycles.
- pix_data, pix_col and pix_last remain stable while pix_valid=1 and pix_ready=0.
- cpu_data_out updates 1 cycle after cpu_rden and holds otherwise.
- A PIXEL_DATA write becomes readable by a scan 1 cycle after the write cycle.
- Simultaneous same-address read/write in single-buffer mode: the read returns old data.

## Configuration
- POV_COLUMN_STREAMER_DOUBLE_BUFFER_EN defined: two banks; swap behaves as described above.
- Undefined:
  - One bank; CPU writes go to the displayed data.
  - CTRL bit1 is ignored; STATUS[9] and [10] read 0.
  - FRAME_CNT still counts column-0 scan starts.

## Test plan
- Reset, then write COL_ADDR=5, LED_ADDR=7, then PIXEL_DATA 0xFF0000 and 0x00FF00 (N_LEDS=8) → (5,7)=0xFF0000 and (6,0)=0x00FF00.
- Write column 4 LEDs 0..7 with values 0x10..0x17, enable=1, set theta=1 (col 4), pix_ready=1 → first pix_valid 3 cycles later; beats 0x10..0x17 arrive at 2-cycle spacing; pix_last only on 0x17.
- Stall pix_ready=0 for 5 cycles mid-column → outputs are held; no beat is lost or duplicated.
- Apply two theta changes during one scan → the current scan finishes and only the latest column scans next.
- Double-buffer: write the back bank, set CTRL=0x3, step theta through 0 → bank toggles at the column-0 scan start, STATUS[9]=0, FRAME_CNT=1, and the new data appears on the stream.
- Assert reset during STREAM → pix_valid=0 the next cycle and all outputs are 0; previously written RAM data still scans out correctly afterwards.
